// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the memory arbiter
package mem_arbiter_pkg;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;
  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} arbState_;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } memTxn_;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority fetch/data arbiter onto a single memory bus with timeout and fetch discard
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic        ifGnt,
  output logic        ifRvalid,
  output logic [31:0] ifRdata,
  output logic        ifFault,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [3:0]  dBe,
  output logic        dGnt,
  output logic        dRvalid,
  output logic [31:0] dRdata,
  output logic        dFault,
  input  logic        fetchFlush,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memReady,
  input  logic [31:0] memRdata,
  input  logic        memErr,
  output logic        stallControl
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  arbState_ state, stateNext;
  memTxn_ txn;
  logic [CW-1:0] count;
  logic discard;
  logic dBusy, iBusy, busy, timeout, done, canGrant, grant, discardNow;
  // every output is gated by reset so nothing leaks while it is held low
  always_comb begin
    dBusy = reset && state == D_BUSY;
    iBusy = reset && state == I_BUSY;
    busy = dBusy || iBusy;
    timeout = busy && !memReady && count == CW'(TIMEOUT_CYCLES - 1);
    done = busy && (memReady || timeout);
    canGrant = reset && (state == IDLE || done);
    dGnt = canGrant && dReq;
    ifGnt = canGrant && ifReq && !dReq;
    grant = dGnt || ifGnt;
    stateNext = dGnt ? D_BUSY : ifGnt ? I_BUSY : done ? IDLE : state;
    discardNow = discard || (iBusy && fetchFlush);
    dRvalid = dBusy && done;
    ifRvalid = iBusy && done && !discardNow;
    dRdata = dRvalid && memReady ? memRdata : '0;
    ifRdata = ifRvalid && memReady ? memRdata : '0;
    dFault = dRvalid && (!memReady || memErr);
    ifFault = ifRvalid && (!memReady || memErr);
    memReq = busy;
    memWe = busy && txn.we;
    memAddr = busy ? txn.addr : '0;
    memWdata = busy ? txn.wdata : '0;
    memBe = busy ? txn.be : '0;
    stallControl = reset && (dReq || state == D_BUSY) && !dRvalid;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      txn <= '0;
      count <= '0;
      discard <= 1'b0;
    end else begin
      state <= stateNext;
      if (dGnt) txn <= '{addr: dAddr, wdata: dWdata, be: dBe, we: dWe};
      else if (ifGnt) txn <= '{addr: ifAddr, wdata: 32'h0, be: 4'hF, we: 1'b0};
      count <= grant || done ? '0 : busy && !memReady ? count + 1'b1 : count;
      discard <= ifGnt ? fetchFlush : done ? 1'b0 : discard || (iBusy && fetchFlush);
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES=4)
module tb_mem_arbiter;
  logic clock = 0, reset = 0;
  logic ifReq = 0, dReq = 0, dWe = 0, fetchFlush = 0, memReady = 0, memErr = 0;
  logic [31:0] ifAddr = 0, dAddr = 0, dWdata = 0, memRdata = 0;
  logic [3:0] dBe = 0;
  logic ifGnt, ifRvalid, ifFault, dGnt, dRvalid, dFault, memReq, memWe, stallControl;
  logic [31:0] ifRdata, dRdata, memAddr, memWdata;
  logic [3:0] memBe;
  int nChecks = 0, nPass = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRvalid(ifRvalid), .ifRdata(ifRdata), .ifFault(ifFault),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dBe(dBe),
    .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata), .dFault(dFault),
    .fetchFlush(fetchFlush),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
    .memReady(memReady), .memRdata(memRdata), .memErr(memErr),
    .stallControl(stallControl)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    dReq = 1; ifReq = 1; memReady = 1;
    nxt(); nxt(); settle();
    checkVal("rst_dGnt", dGnt, 0);
    checkVal("rst_ifGnt", ifGnt, 0);
    checkVal("rst_memReq", memReq, 0);
    checkVal("rst_stall", stallControl, 0);
    checkVal("rst_dRvalid", dRvalid, 0);
    dReq = 0; ifReq = 0; memReady = 0;
    nxt(); reset = 1;
    nxt(); settle();
    checkVal("idle_memReq", memReq, 0);
    checkVal("idle_memAddr", memAddr, 0);
    checkVal("idle_stall", stallControl, 0);

    // fetch only
    ifReq = 1; ifAddr = 32'h100; settle();
    checkVal("f_ifGnt", ifGnt, 1);
    checkVal("f_memReq0", memReq, 0);
    checkVal("f_stall0", stallControl, 0);
    nxt(); ifReq = 0; memReady = 1; memRdata = 32'hCAFE0001; settle();
    checkVal("f_memReq", memReq, 1);
    checkVal("f_memAddr", memAddr, 32'h100);
    checkVal("f_memWe", memWe, 0);
    checkVal("f_memBe", memBe, 4'hF);
    checkVal("f_ifRvalid", ifRvalid, 1);
    checkVal("f_ifRdata", ifRdata, 32'hCAFE0001);
    checkVal("f_ifFault", ifFault, 0);
    checkVal("f_stall1", stallControl, 0);
    nxt(); memReady = 0; settle();
    checkVal("f_done_memReq", memReq, 0);
    checkVal("f_done_ifRvalid", ifRvalid, 0);

    // simultaneous data and fetch, back-to-back
    dReq = 1; dWe = 0; dAddr = 32'h2000; dBe = 4'hF; ifReq = 1; ifAddr = 32'h104; settle();
    checkVal("p_dGnt", dGnt, 1);
    checkVal("p_ifGnt_lose", ifGnt, 0);
    checkVal("p_stall", stallControl, 1);
    nxt(); dReq = 0; memReady = 1; memRdata = 32'h11112222; settle();
    checkVal("p_memAddr_d", memAddr, 32'h2000);
    checkVal("p_dRvalid", dRvalid, 1);
    checkVal("p_dRdata", dRdata, 32'h11112222);
    checkVal("p_ifGnt", ifGnt, 1);
    checkVal("p_stall_done", stallControl, 0);
    nxt(); ifReq = 0; memRdata = 32'h33334444; memErr = 1; settle();
    checkVal("p_memReq_i", memReq, 1);
    checkVal("p_memAddr_i", memAddr, 32'h104);
    checkVal("p_ifRvalid", ifRvalid, 1);
    checkVal("p_ifRdata", ifRdata, 32'h33334444);
    checkVal("p_ifFault", ifFault, 1);
    checkVal("p_dRvalid_i", dRvalid, 0);
    nxt(); memReady = 0; memErr = 0; settle();
    checkVal("p_idle", memReq, 0);

    // store with two wait cycles
    dReq = 1; dWe = 1; dAddr = 32'h3000; dWdata = 32'hDEADBEEF; dBe = 4'b0011; settle();
    checkVal("s_dGnt", dGnt, 1);
    checkVal("s_stall0", stallControl, 1);
    nxt(); dReq = 0; settle();
    checkVal("s_memWe", memWe, 1);
    checkVal("s_memBe", memBe, 4'b0011);
    checkVal("s_memWdata", memWdata, 32'hDEADBEEF);
    checkVal("s_memAddr", memAddr, 32'h3000);
    checkVal("s_stall1", stallControl, 1);
    checkVal("s_dRvalid1", dRvalid, 0);
    nxt(); settle();
    checkVal("s_stall2", stallControl, 1);
    nxt(); memReady = 1; settle();
    checkVal("s_dRvalid", dRvalid, 1);
    checkVal("s_dFault", dFault, 0);
    checkVal("s_stall3", stallControl, 0);
    nxt(); memReady = 0; dWe = 0; settle();
    checkVal("s_idle", memReq, 0);

    // flush one cycle after grant
    ifReq = 1; ifAddr = 32'h200; settle();
    checkVal("x_ifGnt", ifGnt, 1);
    nxt(); ifReq = 0; fetchFlush = 1; settle();
    checkVal("x_memReq", memReq, 1);
    checkVal("x_ifRvalid0", ifRvalid, 0);
    checkVal("x_stall", stallControl, 0);
    nxt(); fetchFlush = 0; memReady = 1; memRdata = 32'h55556666; ifReq = 1; ifAddr = 32'h204; settle();
    checkVal("x_memReq_done", memReq, 1);
    checkVal("x_ifRvalid_sup", ifRvalid, 0);
    checkVal("x_ifGnt2", ifGnt, 1);
    nxt(); ifReq = 0; memRdata = 32'h77778888; settle();
    checkVal("x_memAddr2", memAddr, 32'h204);
    checkVal("x_ifRvalid2", ifRvalid, 1);
    checkVal("x_ifRdata2", ifRdata, 32'h77778888);
    nxt(); memReady = 0; settle();

    // load timeout
    dReq = 1; dAddr = 32'h4000; dBe = 4'hF; memRdata = 32'hFFFFFFFF; settle();
    checkVal("t_dGnt", dGnt, 1);
    nxt(); dReq = 0; settle();
    checkVal("t_b1", dRvalid, 0);
    nxt(); settle();
    checkVal("t_b2", dRvalid, 0);
    nxt(); settle();
    checkVal("t_b3", dRvalid, 0);
    checkVal("t_b3_stall", stallControl, 1);
    nxt(); settle();
    checkVal("t_dRvalid", dRvalid, 1);
    checkVal("t_dFault", dFault, 1);
    checkVal("t_dRdata", dRdata, 0);
    checkVal("t_stall", stallControl, 0);
    nxt(); settle();
    checkVal("t_idle", memReq, 0);
    checkVal("t_idle_rv", dRvalid, 0);

    // reset during a data access
    dReq = 1; dAddr = 32'h5000; settle();
    checkVal("r_dGnt", dGnt, 1);
    nxt(); dReq = 0; settle();
    checkVal("r_memReq", memReq, 1);
    nxt(); reset = 0; memReady = 1; settle();
    checkVal("r_rst_dRvalid", dRvalid, 0);
    nxt(); reset = 1; settle();
    checkVal("r_after_memReq", memReq, 0);
    checkVal("r_after_dRvalid", dRvalid, 0);
    checkVal("r_after_memAddr", memAddr, 0);
    nxt(); memReady = 0; settle();
    checkVal("r_idle_memReq", memReq, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
